save_load_store: RTL and testbench



---
 rtl/save_load_pkg.sv | 26 ++
 rtl/save_load_store_slot_qualifier.sv | 54 +++++
 rtl/save_load_store.sv | 152 +++++++++++++++
 tb/tb_save_load_store.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/save_load_pkg.sv
// Shared slot encodings, arbiter states and request decoding for the save/load snapshot store.
// Slot values must stay in lockstep with the screen FSM's LOC constants.
package save_load_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      LOC1 = 2'd1,
      LOC2 = 2'd2,
      LOC3 = 2'd3
   } slot_e;

   typedef enum logic {
      IDLE      = 1'b0,
      LOAD_PEND = 1'b1
   } arb_state_e;

   localparam int NUM_SLOTS = 3;

   function automatic slot_e decode_sel(input logic [31:0] raw);
      if (raw > 32'd3) begin
         return NONE;
      end
      return slot_e'(raw[1:0]);
   endfunction

endpackage

// File: rtl/save_load_store_slot_qualifier.sv
// Registers one request channel and fires once after the selection holds HOLD_CYCLES stable samples.
// Fire is asserted in the cycle after the HOLD_CYCLES-th matching sample; no backpressure.
module slot_qualifier
   import save_load_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] sel_in,
   output logic [1:0]  slot,
   output logic        fire
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   slot_e      sel_q, sel_d;
   logic [7:0] cnt_q, cnt_d;
   logic       armed_q, armed_d;
   logic       fire_c;

   // Change detect compares the incoming sample with the registered one, so the
   // counter restarts on the same edge that captures the new selection.
   always_comb begin
      sel_d   = decode_sel(sel_in);
      fire_c  = (sel_q != NONE) && armed_q && (cnt_q == HOLD_LAST);
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (sel_d != sel_q) begin
         cnt_d   = 8'd0;
         armed_d = 1'b1;
      end else if (fire_c) begin
         armed_d = 1'b0;
      end else if ((sel_q != NONE) && armed_q) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= NONE;
         cnt_q   <= 8'd0;
         armed_q <= 1'b1;
      end else begin
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   assign slot = sel_q;
   assign fire = fire_c;

endmodule

// File: rtl/save_load_store.sv
// Three-slot snapshot store: qualified saves write a slot, qualified loads drive sensor_output.
// Results land HOLD_CYCLES edges after the first stable sample (+1 for a deferred load); no backpressure.
module save_load_store
   import save_load_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int DATA_W      = 32
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   input  logic [31:0]       save_signal,
   input  logic [31:0]       load_signal,
   input  logic [DATA_W-1:0] sensor_input_to_save,
   output logic [DATA_W-1:0] sensor_output,
   output logic [2:0]        slot_valid,
   output logic              save_done,
   output logic              load_done,
   output logic              load_empty
);

   logic [1:0] save_slot, load_slot;
   logic       save_fire, load_fire;

   slot_qualifier #(.HOLD_CYCLES(HOLD_CYCLES)) u_save_qual (
      .clk    (iVGA_CLK),
      .rst_n  (iRST_n),
      .sel_in (save_signal),
      .slot   (save_slot),
      .fire   (save_fire)
   );

   slot_qualifier #(.HOLD_CYCLES(HOLD_CYCLES)) u_load_qual (
      .clk    (iVGA_CLK),
      .rst_n  (iRST_n),
      .sel_in (load_signal),
      .slot   (load_slot),
      .fire   (load_fire)
   );

   arb_state_e        state_q, state_d;
   logic [1:0]        pend_slot_q, pend_slot_d;
   logic [DATA_W-1:0] slot_q [NUM_SLOTS];
   logic [DATA_W-1:0] slot_d [NUM_SLOTS];
   logic [2:0]        slot_valid_q, slot_valid_d;
   logic [DATA_W-1:0] sensor_output_q, sensor_output_d;
   logic              save_done_q, save_done_d;
   logic              load_done_q, load_done_d;
   logic              load_empty_q, load_empty_d;
   logic              do_read;
   logic [1:0]        rd_slot;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (save_fire && load_fire) state_d = LOAD_PEND;
         LOAD_PEND: state_d = load_fire ? LOAD_PEND : IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Reads always see pre-write slot contents; a load deferred through
   // LOAD_PEND therefore observes a same-cycle save only one cycle later.
   always_comb begin
      slot_d          = slot_q;
      slot_valid_d    = slot_valid_q;
      sensor_output_d = sensor_output_q;
      pend_slot_d     = pend_slot_q;
      save_done_d     = 1'b0;
      load_done_d     = 1'b0;
      load_empty_d    = 1'b0;
      do_read         = 1'b0;
      rd_slot         = 2'd0;

      if (save_fire) begin
         for (int k = 0; k < NUM_SLOTS; k++) begin
            if (save_slot == 2'(k + 1)) begin
               slot_d[k]       = sensor_input_to_save;
               slot_valid_d[k] = 1'b1;
            end
         end
         save_done_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (load_fire && save_fire) begin
               pend_slot_d = load_slot;
            end else if (load_fire) begin
               do_read = 1'b1;
               rd_slot = load_slot;
            end
         end
         LOAD_PEND: begin
            do_read = 1'b1;
            rd_slot = pend_slot_q;
            if (load_fire) begin
               pend_slot_d = load_slot;
            end
         end
         default: ;
      endcase

      if (do_read) begin
         load_done_d     = 1'b1;
         load_empty_d    = 1'b1;
         sensor_output_d = '0;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            if ((rd_slot == 2'(k + 1)) && slot_valid_q[k]) begin
               sensor_output_d = slot_q[k];
               load_empty_d    = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_q[k] <= '0;
         end
         slot_valid_q    <= 3'b000;
         sensor_output_q <= '0;
         pend_slot_q     <= 2'd0;
         save_done_q     <= 1'b0;
         load_done_q     <= 1'b0;
         load_empty_q    <= 1'b0;
      end else begin
         slot_q          <= slot_d;
         slot_valid_q    <= slot_valid_d;
         sensor_output_q <= sensor_output_d;
         pend_slot_q     <= pend_slot_d;
         save_done_q     <= save_done_d;
         load_done_q     <= load_done_d;
         load_empty_q    <= load_empty_d;
      end
   end

   assign sensor_output = sensor_output_q;
   assign slot_valid    = slot_valid_q;
   assign save_done     = save_done_q;
   assign load_done     = load_done_q;
   assign load_empty    = load_empty_q;

endmodule

// File: tb/tb_save_load_store.sv
// Randomised and directed bench for save_load_store against a run-length based reference model.
module tb_save_load_store;

   localparam int H = 4;

   logic        clk;
   logic        rst_n;
   logic [31:0] save_signal, load_signal, data_in;
   logic [31:0] sensor_output;
   logic [2:0]  slot_valid;
   logic        save_done, load_done, load_empty;

   save_load_store #(.HOLD_CYCLES(H), .DATA_W(32)) dut (
      .iVGA_CLK             (clk),
      .iRST_n               (rst_n),
      .save_signal          (save_signal),
      .load_signal          (load_signal),
      .sensor_input_to_save (data_in),
      .sensor_output        (sensor_output),
      .slot_valid           (slot_valid),
      .save_done            (save_done),
      .load_done            (load_done),
      .load_empty           (load_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: slot contents, valid bits, run lengths per channel, pending loads.
   logic [31:0] m_slot [1:3];
   logic [3:1]  m_valid;
   logic [31:0] exp_out;
   logic        exp_sd, exp_ld, exp_le;
   int          s_fire, l_fire, s_last, l_last, s_run, l_run;
   bit          pend_v;
   int          pend_s;

   // Pulse bookkeeping for directed checks.
   int cyc, n_sd, n_ld, n_le, sd_at, ld_at;

   function automatic int dec(input logic [31:0] v);
      return (v > 32'd3) ? 0 : int'(v);
   endfunction

   task automatic model_reset();
      for (int s = 1; s <= 3; s++) m_slot[s] = '0;
      m_valid = '0;
      exp_out = '0;
      exp_sd  = 1'b0;
      exp_ld  = 1'b0;
      exp_le  = 1'b0;
      s_fire  = 0;
      l_fire  = 0;
      s_last  = 0;
      l_last  = 0;
      s_run   = 0;
      l_run   = 0;
      pend_v  = 1'b0;
      pend_s  = 0;
   endtask

   task automatic do_load(input int s);
      exp_ld = 1'b1;
      if (m_valid[s]) begin
         exp_out = m_slot[s];
      end else begin
         exp_out = '0;
         exp_le  = 1'b1;
      end
   endtask

   task automatic model_edge(input logic [31:0] sv, input logic [31:0] lv, input logic [31:0] dat);
      bit serviced;
      int dv;
      serviced = 1'b0;
      exp_sd = 1'b0;
      exp_ld = 1'b0;
      exp_le = 1'b0;
      if (pend_v) begin
         do_load(pend_s);
         pend_v   = 1'b0;
         serviced = 1'b1;
      end
      if (l_fire != 0) begin
         if (s_fire != 0 || serviced) begin
            pend_v = 1'b1;
            pend_s = l_fire;
         end else begin
            do_load(l_fire);
         end
      end
      if (s_fire != 0) begin
         m_slot[s_fire]  = dat;
         m_valid[s_fire] = 1'b1;
         exp_sd          = 1'b1;
      end
      // A run of exactly H identical nonzero samples fires on the following edge.
      dv = dec(sv);
      if (dv == s_last) s_run++;
      else begin s_last = dv; s_run = 1; end
      s_fire = (dv != 0 && s_run == H) ? dv : 0;
      dv = dec(lv);
      if (dv == l_last) l_run++;
      else begin l_last = dv; l_run = 1; end
      l_fire = (dv != 0 && l_run == H) ? dv : 0;
   endtask

   task automatic check_outputs();
      check_eq("sensor_output", sensor_output, exp_out);
      check_eq("slot_valid", {29'b0, slot_valid}, {29'b0, m_valid});
      check_eq("save_done", {31'b0, save_done}, {31'b0, exp_sd});
      check_eq("load_done", {31'b0, load_done}, {31'b0, exp_ld});
      check_eq("load_empty", {31'b0, load_empty}, {31'b0, exp_le});
   endtask

   task automatic cycle(input logic [31:0] sv, input logic [31:0] lv, input logic [31:0] dat);
      save_signal = sv;
      load_signal = lv;
      data_in     = dat;
      @(posedge clk);
      #1;
      model_edge(sv, lv, dat);
      check_outputs();
      if (save_done) begin n_sd++; sd_at = cyc; end
      if (load_done) begin n_ld++; ld_at = cyc; end
      if (load_empty) n_le++;
      cyc++;
   endtask

   task automatic clear_counts();
      cyc = 0; n_sd = 0; n_ld = 0; n_le = 0; sd_at = -1; ld_at = -1;
   endtask

   // Asserts reset away from a clock edge and checks the asynchronous clear before any edge.
   task automatic mid_reset(input int edges);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      repeat (edges) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] pick();
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) return 32'(r % 4);
      return $urandom();
   endfunction

   logic [31:0] sv_r, lv_r, fire_dat, d;

   initial begin
      rst_n       = 1'b0;
      save_signal = '0;
      load_signal = '0;
      data_in     = '0;
      model_reset();
      clear_counts();
      #1;
      check_outputs();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Load from an empty slot right after reset.
      clear_counts();
      for (int i = 0; i < 10; i++) cycle(32'd0, 32'd2, 32'd0);
      check_eq("empty_load_done_cnt", n_ld, 1);
      check_eq("empty_load_empty_cnt", n_le, 1);
      check_eq("empty_load_edge", ld_at, H);
      check_eq("empty_load_out", sensor_output, 32'd0);

      // Save then load.
      clear_counts();
      for (int i = 0; i < 6; i++) cycle(32'd1, 32'd0, 32'hDEADBEEF);
      check_eq("save1_done_cnt", n_sd, 1);
      check_eq("save1_valid", {29'b0, slot_valid}, 32'b001);
      clear_counts();
      for (int i = 0; i < 6; i++) cycle(32'd0, 32'd1, 32'h0);
      check_eq("load1_out", sensor_output, 32'hDEADBEEF);
      check_eq("load1_empty_cnt", n_le, 0);
      check_eq("load1_done_cnt", n_ld, 1);

      // Glitch shorter than the hold time.
      clear_counts();
      for (int i = 0; i < 3; i++) cycle(32'd3, 32'd0, 32'h5555);
      for (int i = 0; i < 4; i++) cycle(32'd0, 32'd0, 32'h5555);
      check_eq("glitch_save_cnt", n_sd, 0);
      check_eq("glitch_valid", {29'b0, slot_valid}, 32'b001);

      // Long hold fires once with the fire-cycle data, re-arms after passing through NONE.
      clear_counts();
      for (int i = 0; i < 50; i++) cycle(32'd2, 32'd0, $urandom());
      check_eq("hold_save_cnt", n_sd, 1);
      cycle(32'd0, 32'd0, 32'h0);
      clear_counts();
      fire_dat = '0;
      for (int i = 0; i < 8; i++) begin
         d = $urandom();
         cycle(32'd2, 32'd0, d);
         if (save_done) fire_dat = d;
      end
      check_eq("rearm_save_cnt", n_sd, 1);
      for (int i = 0; i < 6; i++) cycle(32'd0, 32'd2, 32'h0);
      check_eq("rearm_load_out", sensor_output, fire_dat);

      // Simultaneous save and load of the same slot.
      for (int i = 0; i < 6; i++) cycle(32'd3, 32'd0, 32'h1111);
      for (int i = 0; i < 2; i++) cycle(32'd0, 32'd0, 32'h2222);
      clear_counts();
      for (int i = 0; i < 8; i++) cycle(32'd3, 32'd3, 32'h2222);
      check_eq("simul_save_edge", sd_at, H);
      check_eq("simul_load_edge", ld_at, H + 1);
      check_eq("simul_out", sensor_output, 32'h2222);

      // Reset while a save is partially qualified.
      cycle(32'd0, 32'd0, 32'h0);
      for (int i = 0; i < 2; i++) cycle(32'd1, 32'd0, 32'hCAFE);
      mid_reset(2);
      check_eq("arst_valid", {29'b0, slot_valid}, 32'd0);
      check_eq("arst_out", sensor_output, 32'd0);
      clear_counts();
      for (int i = 0; i < 3; i++) cycle(32'd1, 32'd0, 32'hCAFE);
      check_eq("arst_no_early_save", n_sd, 0);
      for (int i = 0; i < 2; i++) cycle(32'd1, 32'd0, 32'hCAFE);
      check_eq("arst_fresh_save", n_sd, 1);

      // Randomised traffic with occasional asynchronous resets.
      sv_r = '0;
      lv_r = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            sv_r = pick();
            lv_r = sv_r;
         end else begin
            if ($urandom_range(0, 5) == 0) sv_r = pick();
            if ($urandom_range(0, 5) == 0) lv_r = pick();
         end
         if ($urandom_range(0, 499) == 0) mid_reset(1);
         cycle(sv_r, lv_r, $urandom());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
